mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 1, meaning bus cycles from strobe to read-data capture (legal 1..15).
REQ-002 The module SHALL have parameter TIMEOUT, default 255, meaning maximum stall cycles before a transaction is aborted (legal 1..255).
REQ-003 The module SHALL have clk  input  1  system clock (100 MHz); all logic SHALL be on the rising edge.
REQ-004 The module SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have, per requester i in {0,1}: req_i in 1 (hold-high request), we_i in 1 (1=write), addr_i in 15, wdata_i in 8.
REQ-006 The module SHALL have, per requester i: done_i out 1 (one-cycle completion pulse), err_i out 1 (timeout flag, valid with done_i), rdata_i out 8 (read data, valid with done_i, held until next own completion).
REQ-007 The module SHALL have bus_re out 1, bus_we out 1, bus_addr out 15, bus_wdata out 8 driving the peripheral bus.
REQ-008 The module SHALL have bus_rdata in 8 (latched peripheral read data) and bus_stall in 1 (active-high wait request from any peripheral).

Function
REQ-009 States SHALL be IDLE, ISSUE, WAIT, DONE; all outputs SHALL be registered.
REQ-010 In IDLE, if any req_i is high, the arbiter SHALL grant one requester, latch its we/addr/wdata, and enter ISSUE on the next edge.
REQ-011 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; a single requester SHALL be granted immediately; the last-grant pointer SHALL reset to 1 (so requester 0 wins the first tie).
REQ-012 In ISSUE (exactly one cycle), bus_re SHALL equal ~we and bus_we SHALL equal we of the latched transaction; otherwise bus_re/bus_we SHALL be 0.
REQ-013 bus_addr/bus_wdata SHALL be stable from ISSUE through DONE, and retain their last value in IDLE.
REQ-014 WAIT SHALL count WAIT_CYCLES cycles in which bus_stall is low; cycles with bus_stall high SHALL not count.
REQ-015 A 8-bit stall counter SHALL increment each WAIT cycle with bus_stall high; on reaching TIMEOUT, it SHALL go to DONE with err set.
REQ-016 On WAIT->DONE, for reads rdata_g SHALL capture bus_rdata (0xFF on timeout); for writes rdata_g SHALL be unchanged.
REQ-017 In DONE (one cycle), done_g SHALL pulse high, err_g SHALL reflect timeout, other requester's done/err SHALL stay 0; next state IDLE.
REQ-018 Latency without stall SHALL be req sampled at edge N -> ISSUE cycle N+1 -> done pulse in cycle N+2+WAIT_CYCLES.
REQ-019 Dropping req_i mid-transaction SHALL not abort it; done_i still pulses.
REQ-020 A req_i held high after done_i SHALL be treated as a new request in the following IDLE cycle (back-to-back, round-robin still applies).
REQ-021 A request arriving while busy SHALL wait; no request SHALL be lost while held high.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, bus_re=bus_we=0, bus_addr=0, bus_wdata=0, done_i=err_i=0, rdata_i=0, counters=0, last-grant=1.
REQ-023 Reset mid-transaction SHALL abandon it with no done pulse; after release, requests SHALL be arbitrated afresh.

Structure
REQ-024 State encoding and default WAIT_CYCLES/TIMEOUT SHALL live in the shared sysdefs.h header.
REQ-025 The round-robin grant logic SHALL be a sub-module rr_arb2 (req[1:0], last, grant[1:0]).
REQ-026 The block SHALL sit between CPU/DMA masters and mmio; bus_* SHALL connect to mmio re/we/addr/data_write/data_read.

Verification
REQ-027 Single read: req_0, addr_0=0x0300, bus_rdata=0x5A, WAIT_CYCLES=1 -> bus_re one cycle at N+1, done_0 at N+3, rdata_0=0x5A, err_0=0.
REQ-028 Simultaneous writes: req_0 and req_1 high from reset, addr_0=0x0000/0x11, addr_1=0x0200/0x22 -> requester 0 served first, then 1; exactly two bus_we strobes.
REQ-029 Held requests: both req high for 6 transactions -> grants alternate 0,1,0,1,0,1; no starvation.
REQ-030 Stall: bus_stall high 3 cycles during WAIT -> done delayed by exactly 3 cycles, err=0.
REQ-031 Timeout: TIMEOUT=4, bus_stall stuck high on read -> done with err=1, rdata=0xFF after 4 stall cycles; next request proceeds normally.
REQ-032 Reset mid-WAIT: rst_n low one cycle -> all outputs at reset values immediately, no done pulse, subsequent read completes correctly.

Source files
------------

// File: rtl/mmio_arbiter_pkg.sv
// mmio_arbiter_pkg: shared widths, default timing parameters and FSM state encoding for the MMIO arbiter
package mmio_arbiter_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_TIMEOUT = 255;
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant (req[1:0] in, last = requester granted last, grant[1:0] one-hot out)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master MMIO bus arbiter (req/we/addr/wdata in and done/err/rdata out per master, bus_re/we/addr/wdata out, bus_rdata/bus_stall in)
module mmio_arbiter
  import mmio_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              done_0,
  output logic              err_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              done_1,
  output logic              err_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              bus_re,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_stall
);
  localparam logic [3:0] WC_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t state;
  logic last, cur_we, fin, tout, sel_we;
  logic [1:0] grant;
  logic [3:0] wait_cnt;
  logic [7:0] stall_cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_val;
  rr_arb2 u_rr (.req({req_1, req_0}), .last(last), .grant(grant));
  // last doubles as the owner of the transaction in flight
  always_comb begin
    sel_we = grant[1] ? we_1 : we_0;
    sel_addr = grant[1] ? addr_1 : addr_0;
    sel_wdata = grant[1] ? wdata_1 : wdata_0;
    tout = state == WAIT && bus_stall && stall_cnt == TO_LAST;
    fin = tout || (state == WAIT && !bus_stall && wait_cnt == WC_LAST);
    rd_val = tout ? TIMEOUT_RDATA : bus_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      cur_we <= 1'b0;
      wait_cnt <= '0;
      stall_cnt <= '0;
      bus_re <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      err_0 <= 1'b0;
      err_1 <= 1'b0;
      rdata_0 <= '0;
      rdata_1 <= '0;
    end else begin
      bus_re <= 1'b0;
      bus_we <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      err_0 <= 1'b0;
      err_1 <= 1'b0;
      case (state)
        IDLE: if (|grant) begin
          state <= ISSUE;
          last <= grant[1];
          cur_we <= sel_we;
          bus_re <= !sel_we;
          bus_we <= sel_we;
          bus_addr <= sel_addr;
          bus_wdata <= sel_wdata;
          wait_cnt <= '0;
          stall_cnt <= '0;
        end
        ISSUE: state <= WAIT;
        WAIT: if (fin) state <= DONE;
          else if (bus_stall) stall_cnt <= stall_cnt + 8'd1;
          else wait_cnt <= wait_cnt + 4'd1;
        DONE: state <= IDLE;
      endcase
      if (fin) begin
        done_0 <= !last;
        done_1 <= last;
        err_0 <= !last && tout;
        err_1 <= last && tout;
        if (!cur_we && !last) rdata_0 <= rd_val;
        if (!cur_we && last) rdata_1 <= rd_val;
      end
    end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed and randomized checks of mmio_arbiter against a transaction-level schedule model
module tb_mmio_arbiter;
  localparam int WC = 1;
  localparam int TO = 4;
  typedef struct packed {logic we; logic [14:0] a; logic [7:0] d;} txn_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0, bus_stall = 0;
  logic [14:0] addr_0 = '0, addr_1 = '0;
  logic [7:0] wdata_0 = '0, wdata_1 = '0;
  logic done_0, err_0, done_1, err_1, bus_re, bus_we;
  logic [7:0] rdata_0, rdata_1, bus_wdata, bus_rdata;
  logic [14:0] bus_addr;
  txn_t tq [2][32];
  int tn [2];
  int e_m [64], e_iss [64], e_done [64];
  logic e_err [64];
  logic [15:0] e_rdv [64];
  txn_t e_tx [64];
  logic stall_tab [0:1023];
  logic [7:0] pmem [0:32767];
  logic [7:0] sm [int];
  int m_last;
  logic [7:0] m_rd [2];
  int n_cmp = 0, n_bad = 0, last_done;
  logic [15:0] ord;

  always #5 clk = ~clk;
  assign bus_rdata = pmem[bus_addr];

  mmio_arbiter #(.WAIT_CYCLES(WC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .done_0(done_0), .err_0(err_0), .rdata_0(rdata_0),
    .done_1(done_1), .err_1(err_1), .rdata_1(rdata_1),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_stall(bus_stall)
  );

  function automatic logic [7:0] init_val(input logic [14:0] a);
    return 8'(int'(a) * 37 + 11);
  endfunction
  function automatic logic [7:0] mem_val(input logic [14:0] a);
    return sm.exists(int'(a)) ? sm[int'(a)] : init_val(a);
  endfunction
  function automatic txn_t mk(input logic we, input logic [14:0] a, input logic [7:0] d);
    txn_t x;
    x.we = we;
    x.a = a;
    x.d = d;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus_we === 1'b1) pmem[bus_addr] = bus_wdata;
  endtask

  task automatic drive(input int m, input txn_t x);
    if (m == 0) begin we_0 = x.we; addr_0 = x.a; wdata_0 = x.d; end
    else begin we_1 = x.we; addr_1 = x.a; wdata_1 = x.d; end
  endtask

  task automatic set_req(input int m, input logic v);
    if (m == 0) req_0 = v; else req_1 = v;
  endtask

  task automatic fill_stall(input int pct);
    for (int i = 0; i < 1024; i++) stall_tab[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic model_reset();
    m_last = 1;
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_0 = 0;
    req_1 = 0;
    bus_stall = 0;
    model_reset();
    step();
    step();
    chk("reset_vals", {bus_re, bus_we, bus_addr, bus_wdata, done_0, done_1, err_0, err_1, rdata_0, rdata_1}, 0);
    rst_n = 1;
  endtask

  task automatic gen();
    for (int m = 0; m < 2; m++) begin
      tn[m] = $urandom_range(8, 16);
      for (int j = 0; j < tn[m]; j++)
        tq[m][j] = mk(1'($urandom_range(0, 1)), 15'($urandom_range(0, 3) * 256 + $urandom_range(0, 15)), 8'($urandom));
    end
  endtask

  // Predicts grant order, issue/done steps, err and rdata from the arbitration and timing rules, then replays and compares every step.
  task automatic run_pair(input bit drop);
    int p [2];
    int rp [2];
    int nt, iss, c, w, sc, t, m;
    logic [3:0] ev;
    p[0] = 0; p[1] = 0; rp[0] = 0; rp[1] = 0;
    nt = tn[0] + tn[1];
    iss = 1;
    for (int k = 0; k < nt; k++) begin
      m = (p[0] < tn[0] && p[1] < tn[1]) ? 1 - m_last : (p[0] < tn[0] ? 0 : 1);
      m_last = m;
      e_m[k] = m;
      e_tx[k] = tq[m][p[m]];
      p[m]++;
      e_iss[k] = iss;
      w = 0;
      sc = 0;
      c = iss + 1;
      while (!(sc == TO || w == WC)) begin
        if (stall_tab[c]) sc++; else w++;
        c++;
      end
      e_done[k] = c;
      e_err[k] = (sc == TO);
      if (e_tx[k].we) sm[int'(e_tx[k].a)] = e_tx[k].d;
      else m_rd[m] = e_err[k] ? 8'hFF : mem_val(e_tx[k].a);
      e_rdv[k] = {m_rd[1], m_rd[0]};
      iss = c + 2;
    end
    t = 0;
    ord = '0;
    req_0 = tn[0] > 0;
    req_1 = tn[1] > 0;
    if (tn[0] > 0) drive(0, tq[0][0]);
    if (tn[1] > 0) drive(1, tq[1][0]);
    for (int s = 1; s <= e_done[nt-1] + 3; s++) begin
      step();
      bus_stall = stall_tab[s];
      ev = '0;
      if (t < nt) ev = {s == e_done[t] && e_m[t] == 1, s == e_done[t] && e_m[t] == 0,
                        s == e_iss[t] && !e_tx[t].we, s == e_iss[t] && e_tx[t].we};
      chk("strobes", {done_1, done_0, bus_re, bus_we}, ev);
      if (t < nt && drop && s == e_iss[t]) set_req(e_m[t], 1'b0);
      if (t < nt && s == e_done[t]) begin
        m = e_m[t];
        chk("err", {err_1, err_0}, {m == 1 && e_err[t], m == 0 && e_err[t]});
        chk("rdata", {rdata_1, rdata_0}, e_rdv[t]);
        chk("bus_hold", {bus_addr, bus_wdata}, {e_tx[t].a, e_tx[t].d});
        ord = {ord[14:0], done_1};
        rp[m]++;
        if (rp[m] < tn[m]) drive(m, tq[m][rp[m]]); else set_req(m, 1'b0);
        t++;
      end
    end
    bus_stall = 0;
    last_done = e_done[nt-1];
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) pmem[i] = init_val(15'(i));
    do_reset();
    pmem[15'h300] = 8'h5A;
    sm[int'(15'h300)] = 8'h5A;
    tn[0] = 1; tn[1] = 0;
    tq[0][0] = mk(1'b0, 15'h300, 8'h00);
    fill_stall(0);
    run_pair(0);
    chk("single_read_lat", last_done, 3);
    chk("single_read_data", rdata_0, 8'h5A);
    do_reset();
    tn[0] = 1; tn[1] = 1;
    tq[0][0] = mk(1'b1, 15'h000, 8'h11);
    tq[1][0] = mk(1'b1, 15'h200, 8'h22);
    run_pair(0);
    chk("tie_order", ord[1:0], 2'b01);
    chk("tie_second_done", last_done, 7);
    chk("write0_mem", pmem[15'h000], 8'h11);
    chk("write1_mem", pmem[15'h200], 8'h22);
    tn[0] = 3; tn[1] = 3;
    for (int j = 0; j < 3; j++) begin
      tq[0][j] = mk(1'b0, 15'(16 + j), 8'h00);
      tq[1][j] = mk(1'b0, 15'(32 + j), 8'h00);
    end
    run_pair(0);
    chk("alternate6", ord[5:0], 6'b010101);
    tn[0] = 0; tn[1] = 1;
    tq[1][0] = mk(1'b0, 15'h200, 8'h00);
    fill_stall(0);
    for (int i = 2; i < 5; i++) stall_tab[i] = 1'b1;
    run_pair(0);
    chk("stall3_lat", last_done, 6);
    chk("stall3_data", rdata_1, 8'h22);
    tn[0] = 1; tn[1] = 0;
    tq[0][0] = mk(1'b0, 15'h001, 8'h00);
    fill_stall(0);
    for (int i = 2; i < 1024; i++) stall_tab[i] = 1'b1;
    run_pair(0);
    chk("timeout_lat", last_done, 2 + TO);
    chk("timeout_rdata", rdata_0, 8'hFF);
    fill_stall(0);
    tq[0][0] = mk(1'b0, 15'h300, 8'h00);
    run_pair(1);
    chk("after_timeout_data", rdata_0, 8'h5A);
    fill_stall(0);
    req_0 = 1;
    drive(0, mk(1'b0, 15'h155, 8'h00));
    step();
    chk("rst_mid_issue", bus_re, 1'b1);
    step();
    rst_n = 0;
    req_0 = 0;
    #1;
    chk("rst_async", {bus_re, bus_we, bus_addr, bus_wdata, done_0, done_1, err_0, err_1, rdata_0, rdata_1}, 0);
    model_reset();
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_done", {done_1, done_0}, 2'b00);
    end
    tn[0] = 1; tn[1] = 0;
    tq[0][0] = mk(1'b0, 15'h155, 8'h00);
    run_pair(0);
    chk("rst_then_read", rdata_0, mem_val(15'h155));
    do_reset();
    gen();
    fill_stall(40);
    run_pair(0);
    gen();
    fill_stall(15);
    run_pair(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
